// File: rtl/goertzel_pkg.sv
// Shared types and constants for the Goertzel bin detection stage.
// Powers are 16.16 unsigned fixed point throughout.
package goertzel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DECIDE,
        RESTART,
        DRAIN
    } state_t;

    typedef logic [31:0] pwr_t;

    localparam pwr_t THRESH_DEFAULT = 32'h0001_0000;

endpackage

// File: rtl/gbd_max2.sv
// Running strongest / second-strongest tracker fed one power per cycle.
// Strict compares keep the earliest index on ties and push equal later values into second.
module gbd_max2
    import goertzel_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             upd,
    input  logic [31:0]      pwr,
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      max_pwr,
    output logic [31:0]      second_pwr,
    output logic [IDX_W-1:0] max_idx
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            max_pwr    <= '0;
            second_pwr <= '0;
            max_idx    <= '0;
        end else if (clear) begin
            max_pwr    <= '0;
            second_pwr <= '0;
            max_idx    <= '0;
        end else if (upd) begin
            if (pwr > max_pwr) begin
                second_pwr <= max_pwr;
                max_pwr    <= pwr;
                max_idx    <= idx;
            end else if (pwr > second_pwr) begin
                second_pwr <= pwr;
            end
        end
    end

endmodule

// File: rtl/goertzel_bin_detect.sv
// Snapshots all Goertzel bin powers once every engine is valid, scans them for the
// two strongest bins, issues a registered hit/miss decision and pulses an engine restart.
module goertzel_bin_detect
    import goertzel_pkg::*;
#(
    parameter int   NB       = 8,
    parameter pwr_t THRESH   = THRESH_DEFAULT,
    parameter int   RATIO_SH = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [NB-1:0]         pwr_valid_i,
    input  logic [NB*32-1:0]      pwr_i,
    output logic                  det_valid_o,
    output logic                  det_hit_o,
    output logic [$clog2(NB)-1:0] det_bin_o,
    output logic [31:0]           det_pwr_o,
    output logic                  restart_o
);

    localparam int IDX_W = $clog2(NB);
    localparam int CMP_W = 32 + RATIO_SH;

    state_t           state;
    pwr_t             snap [NB];
    logic [IDX_W-1:0] idx;
    logic             start;
    pwr_t             max_pwr;
    pwr_t             second_pwr;
    logic [IDX_W-1:0] max_idx;

    // Peak must clear the absolute floor and dominate the runner-up by 2^RATIO_SH;
    // the widened compare keeps the shifted runner-up from wrapping.
    function automatic logic is_hit(input pwr_t peak, input pwr_t runner);
        logic [CMP_W-1:0] peak_w;
        logic [CMP_W-1:0] runner_w;
        peak_w   = CMP_W'(peak);
        runner_w = CMP_W'(runner) << RATIO_SH;
        return (peak >= THRESH) && (peak_w >= runner_w);
    endfunction

    assign start = (state == IDLE) && en && (&pwr_valid_i);

    gbd_max2 #(
        .IDX_W (IDX_W)
    ) u_max2 (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (start),
        .upd        (state == SCAN),
        .pwr        (snap[idx]),
        .idx        (idx),
        .max_pwr    (max_pwr),
        .second_pwr (second_pwr),
        .max_idx    (max_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            idx         <= '0;
            det_valid_o <= 1'b0;
            det_hit_o   <= 1'b0;
            det_bin_o   <= '0;
            det_pwr_o   <= '0;
            restart_o   <= 1'b0;
            for (int k = 0; k < NB; k++) begin
                snap[k] <= '0;
            end
        end else begin
            det_valid_o <= 1'b0;
            restart_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NB; k++) begin
                            snap[k] <= pwr_i[32*k +: 32];
                        end
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (idx == IDX_W'(NB - 1)) begin
                        state <= DECIDE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DECIDE: begin
                    det_hit_o   <= is_hit(max_pwr, second_pwr);
                    det_bin_o   <= max_idx;
                    det_pwr_o   <= max_pwr;
                    det_valid_o <= 1'b1;
                    state       <= RESTART;
                end
                RESTART: begin
                    restart_o <= 1'b1;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    // Engines hold valid until they are reset; wait for the drop so the
                    // previous frame's sticky valids cannot retrigger a scan.
                    if (pwr_valid_i == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_goertzel_bin_detect.sv
// Randomized and directed bench for goertzel_bin_detect against a sort-based reference model.
module tb_goertzel_bin_detect;

    localparam int NB = 8;

    logic            clk;
    logic            rstn;
    logic            en;
    logic [NB-1:0]   pwr_valid_i;
    logic [NB*32-1:0] pwr_i;
    logic            det_valid_o;
    logic            det_hit_o;
    logic [2:0]      det_bin_o;
    logic [31:0]     det_pwr_o;
    logic            restart_o;

    int tests;
    int fails;

    logic [31:0] pw [NB];
    logic [31:0] exp_pwr;
    logic [31:0] exp_sec;
    logic [2:0]  exp_bin;
    logic        exp_hit;

    goertzel_bin_detect #(
        .NB       (NB),
        .THRESH   (32'h0001_0000),
        .RATIO_SH (3)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .pwr_valid_i (pwr_valid_i),
        .pwr_i       (pwr_i),
        .det_valid_o (det_valid_o),
        .det_hit_o   (det_hit_o),
        .det_bin_o   (det_bin_o),
        .det_pwr_o   (det_pwr_o),
        .restart_o   (restart_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: largest value, second entry of the descending multiset, lowest index of the peak.
    function automatic void model();
        logic [31:0] vals [$];
        for (int k = 0; k < NB; k++) vals.push_back(pw[k]);
        vals.rsort();
        exp_pwr = vals[0];
        exp_sec = vals[1];
        exp_bin = '0;
        for (int k = NB - 1; k >= 0; k--) begin
            if (pw[k] == exp_pwr) exp_bin = 3'(k);
        end
        exp_hit = (exp_pwr >= 32'h0001_0000) && ({32'd0, exp_pwr} >= ({32'd0, exp_sec} * 64'd8));
    endfunction

    task automatic do_frame(input string name, input bit scramble);
        int n;
        int early;
        bit seen;
        model();
        @(negedge clk);
        for (int k = 0; k < NB; k++) pwr_i[32*k +: 32] = pw[k];
        pwr_valid_i = '1;
        en = 1'b1;
        n = 0;
        early = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (scramble && n == 1) begin
                pwr_i = {NB{$urandom}};
                pwr_valid_i = NB'($urandom);
                en = 1'($urandom);
            end
            if (restart_o) early++;
            seen = det_valid_o;
        end
        tests++;
        if (n !== NB + 2 || !seen) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles (seen=%0d), expected %0d", name, n, seen, NB + 2);
            return;
        end
        tests++;
        if (early !== 0) begin
            fails++;
            $display("FAIL %s early_restart: got %0d pulses, expected 0", name, early);
        end
        tests++;
        if (det_hit_o !== exp_hit) begin
            fails++;
            $display("FAIL %s hit: got %0b, expected %0b", name, det_hit_o, exp_hit);
        end
        tests++;
        if (det_bin_o !== exp_bin) begin
            fails++;
            $display("FAIL %s bin: got %0d, expected %0d", name, det_bin_o, exp_bin);
        end
        tests++;
        if (det_pwr_o !== exp_pwr) begin
            fails++;
            $display("FAIL %s pwr: got %h, expected %h", name, det_pwr_o, exp_pwr);
        end
        @(posedge clk);
        #1;
        tests++;
        if (restart_o !== 1'b1 || det_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL %s restart: got restart=%0b valid=%0b, expected 1/0", name, restart_o, det_valid_o);
        end
        @(posedge clk);
        #1;
        tests++;
        if (restart_o !== 1'b0 || det_hit_o !== exp_hit) begin
            fails++;
            $display("FAIL %s hold: got restart=%0b hit=%0b, expected 0/%0b", name, restart_o, det_hit_o, exp_hit);
        end
    endtask

    task automatic release_valids();
        @(negedge clk);
        pwr_valid_i = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_pw(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                          input logic [31:0] a3, input logic [31:0] rest);
        pw[0] = a0; pw[1] = a1; pw[2] = a2; pw[3] = a3;
        for (int k = 4; k < NB; k++) pw[k] = rest;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        en = 1'b0;
        pwr_valid_i = '0;
        pwr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({det_valid_o, det_hit_o, restart_o} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got %b, expected 000", {det_valid_o, det_hit_o, restart_o});
        end
        tests++;
        if (det_bin_o !== 3'd0 || det_pwr_o !== 32'd0) begin
            fails++;
            $display("FAIL reset_data: got bin=%0d pwr=%h, expected 0/0", det_bin_o, det_pwr_o);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_directed();
        set_pw(32'h0001_0000, 32'h0002_0000, 32'h0014_0000, 32'h0001_8000, 32'h0);
        do_frame("tone", 1'b0);
        tests++;
        if (det_hit_o !== 1'b1 || det_bin_o !== 3'd2 || det_pwr_o !== 32'h0014_0000) begin
            fails++;
            $display("FAIL tone_const: got hit=%0b bin=%0d pwr=%h, expected 1/2/00140000",
                     det_hit_o, det_bin_o, det_pwr_o);
        end
        release_valids();
        set_pw(32'h0001_0000, 32'h0004_0000, 32'h0014_0000, 32'h0, 32'h0);
        do_frame("ratio_miss", 1'b0);
        release_valids();
        set_pw(32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);
        do_frame("below_thresh", 1'b0);
        release_valids();
        set_pw(32'h0, 32'h1FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0);
        do_frame("wide_hit", 1'b0);
        release_valids();
        set_pw(32'h0, 32'h2000_0000, 32'h0, 32'hFFFF_FFFF, 32'h0);
        do_frame("wide_miss", 1'b0);
        release_valids();
        set_pw(32'h0, 32'h0007_0000, 32'h0007_0000, 32'h0, 32'h0);
        do_frame("tie_peak", 1'b0);
        release_valids();
    endtask

    task automatic test_random();
        int mode;
        for (int f = 0; f < 24; f++) begin
            mode = $urandom_range(0, 2);
            for (int k = 0; k < NB; k++) begin
                case (mode)
                    0: pw[k] = $urandom;
                    1: pw[k] = $urandom_range(0, 32'h0003_0000);
                    default: pw[k] = 32'h0000_8000 << ($urandom_range(0, 3) * 3);
                endcase
            end
            if (mode == 1 && $urandom_range(0, 1) == 1) pw[$urandom_range(0, NB - 1)] = 32'h0020_0000;
            do_frame("random", 1'b1);
            release_valids();
        end
    endtask

    task automatic test_sticky_and_en();
        int strobes;
        set_pw(32'h0, 32'h0, 32'h0, 32'h0030_0000, 32'h0000_1000);
        do_frame("sticky_first", 1'b0);
        strobes = 0;
        repeat (33) begin
            @(posedge clk);
            #1;
            strobes += int'(det_valid_o) + int'(restart_o);
        end
        tests++;
        if (strobes !== 0) begin
            fails++;
            $display("FAIL sticky_retrigger: got %0d strobes, expected 0", strobes);
        end
        release_valids();
        @(negedge clk);
        en = 1'b0;
        pwr_valid_i = '1;
        strobes = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            strobes += int'(det_valid_o) + int'(restart_o);
        end
        tests++;
        if (strobes !== 0) begin
            fails++;
            $display("FAIL en_low_scan: got %0d strobes, expected 0", strobes);
        end
        set_pw(32'h0000_4000, 32'h0009_0000, 32'h0, 32'h0, 32'h0);
        do_frame("en_high", 1'b0);
        release_valids();
    endtask

    task automatic test_reset_mid();
        set_pw(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        pwr_valid_i = '1;
        en = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        tests++;
        if ({det_valid_o, det_hit_o, restart_o} !== 3'b000 || det_bin_o !== 3'd0 || det_pwr_o !== 32'd0) begin
            fails++;
            $display("FAIL mid_reset: got v=%0b h=%0b r=%0b bin=%0d pwr=%h, expected all 0",
                     det_valid_o, det_hit_o, restart_o, det_bin_o, det_pwr_o);
        end
        @(negedge clk);
        pwr_valid_i = '0;
        rstn = 1'b1;
        set_pw(32'h0002_0000, 32'h0, 32'h0, 32'h0, 32'h0011_0000);
        do_frame("post_reset", 1'b0);
        release_valids();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_random();
        test_sticky_and_en();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
